flt2fix_iter: RTL and testbench

//  Parametrised, multi-cycle IEEE-style float -> two's-complement fixed-point converter; successor to the 8.8 half-float model.

---
 rtl/flt2fix_pkg.sv | 37 +++
 rtl/flt2fix_iter_round.sv | 46 ++++
 rtl/flt2fix_iter.sv | 152 +++++++++++++++
 tb/tb_flt2fix_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flt2fix_pkg.sv
// Shared types and format helpers for the iterative float -> fixed-point converter.
package flt2fix_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    DECODE = ST_DECODE,
    SHIFT  = ST_SHIFT,
    ROUND  = ST_ROUND,
    DONE   = ST_DONE
  } state_t;

  typedef struct packed {
    logic ovf;
    logic inexact;
    logic nan;
  } flags_t;

  function automatic int calc_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

  function automatic int calc_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  // Shift counter must hold the cap W+2.
  function automatic int calc_cnt_w(input int w);
    return $clog2(w + 3);
  endfunction

endpackage

// File: rtl/flt2fix_iter_round.sv
// Rounding, saturation and sign application for the aligned magnitude.
module fix_round_sat
  import flt2fix_pkg::*;
#(
  parameter int W        = 16,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [W:0]   mag,
  input  logic         g,
  input  logic         s,
  input  logic         sat,
  input  logic         sign,
  input  logic         nan,
  output logic [W-1:0] fix_out,
  output flags_t       flags
);

  localparam logic [W+1:0] HALF    = (W + 2)'(1) << (W - 1);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W - 1){1'b0}}};

  logic         rnd_up;
  logic [W+1:0] mag_r;
  logic         over;

  always_comb begin
    rnd_up = ROUND_EN && g && (s || mag[0]);
    mag_r  = {1'b0, mag} + {{(W + 1){1'b0}}, rnd_up};
    // Negative range reaches one further than positive: -2**(W-1) is exact.
    if (sign) over = sat || (mag_r > HALF);
    else      over = sat || (mag_r >= HALF);

    flags   = '0;
    fix_out = '0;
    if (nan) begin
      flags.nan = 1'b1;
    end else if (over) begin
      flags.ovf = 1'b1;
      fix_out   = sign ? NEG_MIN : POS_MAX;
    end else begin
      flags.inexact = g | s;
      fix_out       = sign ? (~mag_r[W-1:0] + W'(1)) : mag_r[W-1:0];
    end
  end

endmodule

// File: rtl/flt2fix_iter.sv
// Multi-cycle float -> signed fixed-point converter with a 1-bit-per-cycle aligner.
//  state  | meaning
//  IDLE   | waiting for start; operand captured on accept
//  DECODE | split fields, derive shift direction/count, flag Inf/NaN
//  SHIFT  | one alignment step per cycle (left with sat detect, right via G/S)
//  ROUND  | round/saturate/sign, register results, pulse done
//  DONE   | done visible; busy still high, drops next cycle
module flt2fix_iter
  import flt2fix_pkg::*;
#(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 8,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [EXP_W+MAN_W:0]           flt_in,
  output logic                           busy,
  output logic                           done,
  output logic [INT_W+FRAC_W-1:0]        fix_out,
  output logic                           ovf,
  output logic                           inexact,
  output logic                           nan
);

  localparam int W     = calc_w(INT_W, FRAC_W);
  localparam int BIAS  = calc_bias(EXP_W);
  localparam int CNT_W = calc_cnt_w(W);

  state_t                 state;
  logic [EXP_W+MAN_W:0]   flt_q;
  logic [W:0]             work_q;
  logic                   g_q;
  logic                   s_q;
  logic                   sat_q;
  logic                   nan_q;
  logic                   left_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [EXP_W-1:0]       exp_f;
  logic [EXP_W-1:0]       e_eff;
  logic [MAN_W-1:0]       man_f;
  logic [MAN_W:0]         sig;
  logic                   special;
  int                     sh_i;
  int                     sh_abs;
  logic [CNT_W-1:0]       cnt_d;

  logic [W-1:0]           rs_fix;
  flags_t                 rs_flags;

  always_comb begin
    exp_f   = flt_q[EXP_W+MAN_W-1:MAN_W];
    man_f   = flt_q[MAN_W-1:0];
    e_eff   = (exp_f == '0) ? EXP_W'(1) : exp_f;
    sig     = {exp_f != '0, man_f};
    special = &exp_f;
    sh_i    = int'(e_eff) - BIAS - MAN_W + FRAC_W;
    sh_abs  = (sh_i < 0) ? -sh_i : sh_i;
    // Beyond W+2 steps every bit is already in sticky (right) or saturated (left).
    cnt_d   = (sh_abs > W + 2) ? CNT_W'(W + 2) : CNT_W'(sh_abs);
  end

  fix_round_sat #(
    .W        (W),
    .ROUND_EN (ROUND_EN)
  ) u_round_sat (
    .mag     (work_q),
    .g       (g_q),
    .s       (s_q),
    .sat     (sat_q),
    .sign    (flt_q[EXP_W+MAN_W]),
    .nan     (nan_q),
    .fix_out (rs_fix),
    .flags   (rs_flags)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      flt_q   <= '0;
      work_q  <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      sat_q   <= 1'b0;
      nan_q   <= 1'b0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fix_out <= '0;
      ovf     <= 1'b0;
      inexact <= 1'b0;
      nan     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            flt_q <= flt_in;
            busy  <= 1'b1;
            state <= DECODE;
          end
        end
        DECODE: begin
          work_q <= {{(W - MAN_W){1'b0}}, sig};
          g_q    <= 1'b0;
          s_q    <= 1'b0;
          sat_q  <= special && (man_f == '0);
          nan_q  <= special && (man_f != '0);
          left_q <= (sh_i > 0);
          cnt_q  <= cnt_d;
          if (special || cnt_d == '0) state <= ROUND;
          else                        state <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (left_q) begin
            work_q <= {work_q[W-1:0], 1'b0};
            sat_q  <= sat_q | work_q[W-1] | work_q[W];
            if (cnt_q == CNT_W'(1) || work_q[W-1]) state <= ROUND;
          end else begin
            work_q <= {1'b0, work_q[W:1]};
            g_q    <= work_q[0];
            s_q    <= s_q | g_q;
            if (cnt_q == CNT_W'(1)) state <= ROUND;
          end
        end
        ROUND: begin
          fix_out <= rs_fix;
          ovf     <= rs_flags.ovf;
          inexact <= rs_flags.inexact;
          nan     <= rs_flags.nan;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flt2fix_iter.sv
// Bench for flt2fix_iter: rounding and truncating instances side by side.
module tb_flt2fix_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] flt_in = '0;

  logic        busy_r, done_r, ovf_r, inexact_r, nan_r;
  logic [15:0] fix_r;
  logic        busy_t, done_t, ovf_t, inexact_t, nan_t;
  logic [15:0] fix_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flt2fix_iter #(.EXP_W(5), .MAN_W(10), .INT_W(8), .FRAC_W(8), .ROUND_EN(1'b1)) dut_rne (
    .clk(clk), .reset(reset), .start(start), .flt_in(flt_in),
    .busy(busy_r), .done(done_r), .fix_out(fix_r),
    .ovf(ovf_r), .inexact(inexact_r), .nan(nan_r));

  flt2fix_iter #(.EXP_W(5), .MAN_W(10), .INT_W(8), .FRAC_W(8), .ROUND_EN(1'b0)) dut_trn (
    .clk(clk), .reset(reset), .start(start), .flt_in(flt_in),
    .busy(busy_t), .done(done_t), .fix_out(fix_t),
    .ovf(ovf_t), .inexact(inexact_t), .nan(nan_t));

  typedef struct {
    logic [15:0] f;
    logic [15:0] fix_rne;
    logic [2:0]  fl_rne;   // {ovf, inexact, nan}
    logic [15:0] fix_trn;
    logic [2:0]  fl_trn;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: exact scaled value sig*2**sh, rounded by integer division.
  function automatic void model(input logic [15:0] f, input bit rne,
                                output logic [15:0] fx, output logic [2:0] fl, output int lat);
    int sgn, e, man, sig, sh, n, msb;
    longint mag, q, rem, d;
    bit inx;
    sgn = int'(f[15]);
    e   = int'(f[14:10]);
    man = int'(f[9:0]);
    inx = 1'b0;
    if (e == 31) begin
      lat = 3;
      if (man != 0) begin fx = 16'h0000; fl = 3'b001; end
      else begin fx = (sgn != 0) ? 16'h8000 : 16'h7FFF; fl = 3'b100; end
      return;
    end
    sig = (e == 0) ? man : 1024 + man;
    sh  = ((e == 0) ? 1 : e) - 15 - 10 + 8;
    if (sh >= 0) begin
      mag = longint'(sig) <<< sh;
      msb = 0;
      for (int i = 0; i < 11; i++) if (((sig >> i) & 1) != 0) msb = i;
      n = sh;
      if (16 - msb < n) n = 16 - msb;
    end else begin
      d   = 64'sd1 <<< (-sh);
      q   = longint'(sig) / d;
      rem = longint'(sig) % d;
      inx = (rem != 0);
      if (rne && ((2 * rem > d) || ((2 * rem == d) && (q % 2 == 1)))) q = q + 1;
      mag = q;
      n = (-sh > 18) ? 18 : -sh;
    end
    lat = 3 + n;
    if (sgn == 0 && mag >= 32768) begin fx = 16'h7FFF; fl = 3'b100; end
    else if (sgn != 0 && mag > 32768) begin fx = 16'h8000; fl = 3'b100; end
    else begin
      fx = (sgn != 0) ? 16'(-mag) : 16'(mag);
      fl = {1'b0, inx, 1'b0};
    end
  endfunction

  task automatic run_op(input logic [15:0] f,
                        output logic [15:0] fr, output logic [2:0] flr,
                        output logic [15:0] ft, output logic [2:0] flt, output int lat);
    int cyc;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; flt_in = f;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on", {31'b0, busy_r}, 32'd1);
    cyc = 1; got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done_r) got = 1'b1;
    end
    lat = got ? cyc : -1;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    fr  = fix_r; flr = {ovf_r, inexact_r, nan_r};
    ft  = fix_t; flt = {ovf_t, inexact_t, nan_t};
    chk("done_trn_sync", {31'b0, done_t}, {31'b0, got});
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done_r}, 32'd0);
    chk("busy_drop", {31'b0, busy_r}, 32'd0);
  endtask

  vec_t        vecs[13];
  logic [15:0] fr, ft, efr, eft;
  logic [2:0]  flr, flt, eflr, eflt;
  int          lat, elat, elat2;

  initial begin
    vecs[0]  = '{16'h3C00, 16'h0100, 3'b000, 16'h0100, 3'b000, 5};
    vecs[1]  = '{16'hBC00, 16'hFF00, 3'b000, 16'hFF00, 3'b000, 5};
    vecs[2]  = '{16'h5C00, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 9};
    vecs[3]  = '{16'hD800, 16'h8000, 3'b000, 16'h8000, 3'b000, 8};
    vecs[4]  = '{16'h1800, 16'h0000, 3'b010, 16'h0000, 3'b010, 14};
    vecs[5]  = '{16'h1E00, 16'h0002, 3'b010, 16'h0001, 3'b010, 13};
    vecs[6]  = '{16'h0001, 16'h0000, 3'b010, 16'h0000, 3'b010, 19};
    vecs[7]  = '{16'h7C00, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 3};
    vecs[8]  = '{16'hFC00, 16'h8000, 3'b100, 16'h8000, 3'b100, 3};
    vecs[9]  = '{16'h7E00, 16'h0000, 3'b001, 16'h0000, 3'b001, 3};
    vecs[10] = '{16'h8000, 16'h0000, 3'b000, 16'h0000, 3'b000, 19};
    vecs[11] = '{16'h57FF, 16'h7FF0, 3'b000, 16'h7FF0, 3'b000, 7};
    vecs[12] = '{16'hD801, 16'h8000, 3'b100, 16'h8000, 3'b100, 8};

    #12;
    chk("rst_busy", {31'b0, busy_r}, 32'd0);
    chk("rst_done", {31'b0, done_r}, 32'd0);
    chk("rst_fix", {16'b0, fix_r}, 32'd0);
    chk("rst_flags", {29'b0, ovf_r, inexact_r, nan_r}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].f, fr, flr, ft, flt, lat);
      chk($sformatf("vec%0d_fix_rne", i), {16'b0, fr}, {16'b0, vecs[i].fix_rne});
      chk($sformatf("vec%0d_fl_rne", i), {29'b0, flr}, {29'b0, vecs[i].fl_rne});
      chk($sformatf("vec%0d_fix_trn", i), {16'b0, ft}, {16'b0, vecs[i].fix_trn});
      chk($sformatf("vec%0d_fl_trn", i), {29'b0, flt}, {29'b0, vecs[i].fl_trn});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 150; i++) begin
      logic [15:0] f;
      f = 16'($urandom_range(0, 65535));
      model(f, 1'b1, efr, eflr, elat);
      model(f, 1'b0, eft, eflt, elat2);
      run_op(f, fr, flr, ft, flt, lat);
      chk($sformatf("rnd_fix_rne_%h", f), {16'b0, fr}, {16'b0, efr});
      chk($sformatf("rnd_fl_rne_%h", f), {29'b0, flr}, {29'b0, eflr});
      chk($sformatf("rnd_fix_trn_%h", f), {16'b0, ft}, {16'b0, eft});
      chk($sformatf("rnd_fl_trn_%h", f), {29'b0, flt}, {29'b0, eflt});
      chk($sformatf("rnd_lat_%h", f), 32'(lat), 32'(elat));
    end

    // start re-pulsed while busy must be dropped
    begin
      int ndone;
      logic [15:0] first_fix;
      ndone = 0; first_fix = '0;
      @(posedge clk); #1; start = 1'b1; flt_in = 16'h3C00;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; start = 1'b1; flt_in = 16'h5C00;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (done_r) begin
          ndone++;
          if (ndone == 1) first_fix = fix_r;
        end
      end
      chk("busy_ignore_ndone", 32'(ndone), 32'd1);
      chk("busy_ignore_fix", {16'b0, first_fix}, 32'h0100);
    end

    // back-to-back with start held high
    begin
      int cyc, d1, d2;
      logic [15:0] f1, f2;
      cyc = 0; d1 = -1; d2 = -1; f1 = '0; f2 = '0;
      @(posedge clk); #1; start = 1'b1; flt_in = 16'h3C00;
      @(posedge clk); #1; flt_in = 16'hBC00; cyc = 1;
      while (d2 < 0 && cyc < 60) begin
        @(posedge clk); #1; cyc++;
        if (done_r) begin
          if (d1 < 0) begin d1 = cyc; f1 = fix_r; end
          else begin d2 = cyc; f2 = fix_r; start = 1'b0; end
        end
      end
      start = 1'b0;
      chk("b2b_first_lat", 32'(d1), 32'd5);
      chk("b2b_gap", 32'(d2 - d1), 32'd6);
      chk("b2b_fix1", {16'b0, f1}, 32'h0100);
      chk("b2b_fix2", {16'b0, f2}, 32'hFF00);
    end

    // reset in the middle of SHIFT
    begin
      int seen;
      run_op(16'hBC00, fr, flr, ft, flt, lat);
      chk("pre_rst_fix", {16'b0, fr}, 32'hFF00);
      @(posedge clk); #1; start = 1'b1; flt_in = 16'h0001;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #2; reset = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy_r}, 32'd0);
      chk("midrst_done", {31'b0, done_r}, 32'd0);
      chk("midrst_fix", {16'b0, fix_r}, 32'd0);
      chk("midrst_fix_trn", {16'b0, fix_t}, 32'd0);
      @(posedge clk); #1; reset = 1'b1;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (done_r || busy_r) seen++;
      end
      chk("midrst_quiet", 32'(seen), 32'd0);
      run_op(16'h3C00, fr, flr, ft, flt, lat);
      chk("postrst_fix", {16'b0, fr}, 32'h0100);
      chk("postrst_flags", {29'b0, flr}, 32'd0);
      chk("postrst_lat", 32'(lat), 32'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
